// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, instruction field positions and NOP encoding
package cpu_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // Opcode occupies the top three bits of every instruction word
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;

  localparam logic [DATA_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode(input logic [DATA_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush, holding {pc, word} entries
module fetch_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  store [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = store[rd_ptr[AW-1:0]];

  // Pointer update; flush discards every entry at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // Storage write; contents need no reset because empty masks them downstream
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch with prefetch FIFO, rewind and redirect
module instr_fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       mem_r_en,
  output logic [ADDR_W-1:0]          mem_r_adrs,
  input  logic [DATA_W-1:0]          mem_data_out,
  input  logic                       mem_r_valid,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_W-1:0]          inst_word,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  import cpu_pkg::NOP;

  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        fetch_pc;
  logic                     inflight;
  logic                     push;
  logic                     lost;
  logic                     issue;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] head;

  // The response belongs to the cycle in which the registered request is presented,
  // so the outstanding-read flag is exactly the registered request strobe
  assign inflight = mem_r_en;

  // A redirect kills the response of any read that is still outstanding
  assign push = inflight & mem_r_valid & ~redirect;
  assign lost = inflight & ~mem_r_valid & ~redirect;

  // A dropped response rewinds fetch to the address that was lost
  assign fetch_pc = lost ? mem_r_adrs : pc;

  // Credit excludes a same-cycle pop, so the FIFO can never be pushed while full
  assign issue = fetch_en & ~redirect & ((int'(fifo_level) + int'(inflight)) < DEPTH);

  // PC and read-request registers; redirect takes priority over normal issue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc         <= RESET_PC;
      mem_r_en   <= 1'b0;
      mem_r_adrs <= RESET_PC;
    end else if (redirect) begin
      mem_r_en <= fetch_en;
      if (fetch_en) begin
        mem_r_adrs <= redirect_pc;
        pc         <= redirect_pc + ADDR_W'(1);
      end else begin
        pc <= redirect_pc;
      end
    end else begin
      mem_r_en <= issue;
      if (issue) begin
        mem_r_adrs <= fetch_pc;
        pc         <= fetch_pc + ADDR_W'(1);
      end else begin
        pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (inst_ready),
    .flush  (redirect),
    .wdata  ({mem_r_adrs, mem_data_out}),
    .rdata  (head),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Head is shown combinationally; an empty FIFO presents NOP at address 0
  assign inst_valid = ~fifo_empty;
  assign inst_pc    = inst_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign inst_word  = inst_valid ? head[DATA_W-1:0] : DATA_W'(NOP);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC = '0;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              fetch_en = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_r_adrs;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_r_valid;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [DATA_W-1:0] inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic [LW-1:0]     fifo_level;

  // Memory fault injection and shared-valid noise
  logic              drop_en = 1'b0;
  logic [ADDR_W-1:0] drop_addr = '0;
  int                drop_count = 0;
  logic              spurious = 1'b0;

  int errors = 0;
  int checks = 0;

  // Delivery model: the accepted stream must be contiguous from the last restart point
  logic [ADDR_W-1:0] exp_pc = RST_PC;
  int                delivered = 0;
  int                seen5 = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fetch_en     (fetch_en),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_r_en     (mem_r_en),
    .mem_r_adrs   (mem_r_adrs),
    .mem_data_out (mem_data_out),
    .mem_r_valid  (mem_r_valid),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_word    (inst_word),
    .inst_pc      (inst_pc),
    .fifo_level   (fifo_level)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  // Read port answers the presented request; garbage data outside a request
  assign mem_data_out = mem_r_en ? mem_word(mem_r_adrs) : 32'hDEAD_BEEF;
  assign mem_r_valid  = spurious |
                        (mem_r_en & ~(drop_en & (drop_count == 0) & (mem_r_adrs == drop_addr)));

  // Drop only the first read of the selected address
  always @(posedge clk) begin
    if (mem_r_en && drop_en && drop_count == 0 && mem_r_adrs == drop_addr)
      drop_count <= drop_count + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the delivery model
  always @(negedge clk) begin
    if (!resetn) begin
      exp_pc = RST_PC;
    end else begin
      check("level_bound", fifo_level <= DEPTH, 1);
      check("valid_vs_level", inst_valid, fifo_level != 0);
      if (inst_valid && inst_ready) begin
        check("model_pc", inst_pc, exp_pc);
        check("model_word", inst_word, mem_word(exp_pc));
        if (inst_pc == ADDR_W'(5)) seen5++;
        exp_pc = exp_pc + ADDR_W'(1);
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
  end

  initial begin
    int found;
    int s5;

    // Reset state
    #2 resetn = 1'b0;
    inst_ready = 1'b1;
    tick(2);
    check("rst_mem_r_en", mem_r_en, 0);
    check("rst_mem_r_adrs", mem_r_adrs, RST_PC);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_word", inst_word, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fifo_level", fifo_level, 0);
    resetn = 1'b1;
    tick(1);

    // Test 1: start-up latency and first sequence
    fetch_en = 1'b1;
    tick(1);
    check("t1_first_issue", mem_r_en, 1);
    check("t1_not_yet_valid", inst_valid, 0);
    tick(1);
    check("t1_valid_after_2", inst_valid, 1);
    check("t1_pc0", inst_pc, 0);
    tick(1);
    check("t1_pc1", inst_pc, 1);
    tick(1);
    check("t1_pc2", inst_pc, 2);
    tick(1);
    check("t1_pc3", inst_pc, 3);

    // Test 2: backpressure fills FIFO; shared valid noise must be ignored
    inst_ready = 1'b0;
    spurious   = 1'b1;
    tick(10);
    check("t2_level_full", fifo_level, 4);
    check("t2_issue_stopped", mem_r_en, 0);
    spurious   = 1'b0;
    inst_ready = 1'b1;
    tick(12);

    // Test 3: redirect with 3 entries queued and one read outstanding
    inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (fifo_level == 3 && mem_r_en) found = 1;
      else tick(1);
    end
    check("t3_reach_level3", found, 1);
    redirect    = 1'b1;
    redirect_pc = ADDR_W'(11'h100);
    tick(1);
    redirect = 1'b0;
    check("t3_flushed", inst_valid, 0);
    check("t3_level0", fifo_level, 0);
    check("t3_reissue", mem_r_en, 1);
    check("t3_adrs", mem_r_adrs, 11'h100);
    tick(1);
    check("t3_first_pc", inst_pc, 11'h100);
    inst_ready = 1'b1;
    tick(6);

    // Test 4: wrap of the PC
    redirect    = 1'b1;
    redirect_pc = ADDR_W'(2046);
    tick(1);
    redirect = 1'b0;
    check("t4_adrs", mem_r_adrs, 2046);
    tick(1);
    check("t4_pc2046", inst_pc, 2046);
    tick(1);
    check("t4_pc2047", inst_pc, 2047);
    tick(1);
    check("t4_pc0", inst_pc, 0);
    tick(1);
    check("t4_pc1", inst_pc, 1);

    // Test 5: lost response for address 5 is re-fetched once, in order
    s5          = seen5;
    drop_en     = 1'b1;
    drop_addr   = ADDR_W'(5);
    redirect    = 1'b1;
    redirect_pc = ADDR_W'(3);
    tick(1);
    redirect = 1'b0;
    tick(1);
    check("t5_pc3", inst_pc, 3);
    tick(1);
    check("t5_pc4", inst_pc, 4);
    check("t5_adrs5", mem_r_adrs, 5);
    tick(1);
    check("t5_gap", inst_valid, 0);
    check("t5_reissue_en", mem_r_en, 1);
    check("t5_reissue_adrs", mem_r_adrs, 5);
    tick(1);
    check("t5_pc5", inst_pc, 5);
    tick(1);
    check("t5_pc6", inst_pc, 6);
    tick(4);
    check("t5_dropped_once", drop_count, 1);
    check("t5_five_once", seen5 - s5, 1);
    drop_en = 1'b0;

    // Test 6: asynchronous reset mid-stream
    tick(3);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_en", mem_r_en, 0);
    check("t6_rst_adrs", mem_r_adrs, RST_PC);
    check("t6_rst_valid", inst_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_word", inst_word, 0);
    check("t6_rst_pc", inst_pc, 0);
    @(posedge clk);
    #3 resetn = 1'b1;
    tick(1);
    check("t6_restart_en", mem_r_en, 1);
    check("t6_restart_adrs", mem_r_adrs, RST_PC);
    tick(1);
    check("t6_restart_pc", inst_pc, RST_PC);
    check("t6_restart_word", inst_word, mem_word(RST_PC));
    tick(6);
    check("delivered_enough", delivered >= 40, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
